mb_clk_repair_ctrl: RTL and testbench
=====================================

Name: mb_clk_repair_ctrl

Overview:
Sequencer for the mainband clock-repair step (MBINIT.REPAIRCLK).
- Enables the clock pattern generator and waits for its done.
- Collects per-lane detector results for CKP, CKN and Track from the partner.
- Decides on a repair of at most one clock lane, then runs one verify pass with the repair applied.
- Sits between the MBINIT state machine and the clock pattern generator / lane-repair mux.

Parameters:
- TIMEOUT_CYCLES, 8000: cycles allowed in PATTERN or WAIT_RESULT before declaring timeout.
- TMR_W, 13: timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- i_sys_clk  in  1  block clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  level; starts a repair sequence when sampled high in IDLE, DONE or FAIL
- i_abort  in  1  returns the block to IDLE from any state
- i_gen_done  in  1  pattern generator done
- i_result_valid  in  1  one-cycle strobe: partner detector results available
- i_ckp_ok  in  1  CKP pattern detected correctly; qualified by i_result_valid
- i_ckn_ok  in  1  CKN pattern detected correctly; qualified by i_result_valid
- i_trk_ok  in  1  Track pattern detected correctly; qualified by i_result_valid
- o_pattern_en  out  1  drives the generator state indicator (pattern send enable)
- o_busy  out  1  sequence in progress
- o_repair_code  out  2  00 none, 01 CKP, 10 CKN, 11 Track
- o_repair_valid  out  1  o_repair_code is applied to the lane mux
- o_done  out  1  sequence passed (sticky)
- o_fail  out  1  sequence failed (sticky)
- o_timeout  out  1  the fail was caused by timeout (sticky with o_fail)

Behaviour:
- Clocking and reset: one clock, i_sys_clk; reset is asynchronous and active-low on i_rst_n. All outputs are registered and reset to 0. State resets to IDLE, the pass flag to 0.
- States: IDLE, PATTERN, WAIT_RESULT, DECIDE, DONE, FAIL.
- IDLE: i_start=1 -> PATTERN. In the same edge: o_pattern_en=1, o_busy=1, pass=0, o_repair_code=00, o_repair_valid=0, o_done/o_fail/o_timeout=0.
- PATTERN: o_pattern_en stays 1 until i_gen_done=1.
  - On i_gen_done: o_pattern_en=0 at the next edge and move to WAIT_RESULT.
  - Latency from i_gen_done high to o_pattern_en low: exactly 1 cycle.
- WAIT_RESULT: on i_result_valid, register {ckp,ckn,trk}_ok and move to DECIDE. i_result_valid in any other state is ignored.
- DECIDE (1 cycle): nfail = count of zero ok-bits (2-bit sum).
  - pass=0, nfail=0 -> DONE, code 00.
  - pass=0, nfail=1 -> code = the failing lane, o_repair_valid=1, pass=1, PATTERN with o_pattern_en=1 (verify pass).
  - pass=0, nfail>=2 -> FAIL.
  - pass=1, nfail=0 -> DONE; code and valid are retained.
  - pass=1, nfail>=1 -> FAIL.
- DONE: o_done=1, o_busy=0.
- FAIL: o_fail=1, o_busy=0, o_repair_valid=0.
- Restart: i_start=1 in DONE or FAIL restarts as from IDLE; all results are cleared. i_start is ignored while o_busy=1.
- Abort: i_abort=1 in any non-IDLE state -> IDLE next cycle with all outputs 0. i_abort has priority over every other event.
- Timeout counter:
  - Clears on entry to PATTERN and to WAIT_RESULT; counts each cycle in those states.
  - At count == TIMEOUT_CYCLES-1 without the awaited event: FAIL, o_timeout=1, o_pattern_en=0.
  - i_gen_done or i_result_valid in the same cycle as expiry: the event wins.
- Asynchronous reset mid-sequence: immediate IDLE with all outputs 0. The generator therefore stops at once.

Optional Feature:
- Macro: MB_CLKREPAIR_TIMEOUT_EN.
- Defined: timeout counter and o_timeout are present as described.
- Undefined: no counter. PATTERN and WAIT_RESULT wait indefinitely; o_timeout is tied to 0.

Decomposition:
- Package mb_clk_repair_pkg:
  - state encoding localparams (IDLE=0 ... FAIL=5);
  - repair codes REP_NONE/REP_CKP/REP_CKN/REP_TRK;
  - default TIMEOUT_CYCLES.
- One sub-module, mb_clk_repair_timer:
  - clear/enable inputs and an expired output, parameterized by TIMEOUT_CYCLES and TMR_W;
  - instantiated only under MB_CLKREPAIR_TIMEOUT_EN.

Test Plan:
- Clean pass: start; gen_done at cycle 50; result 111 -> o_pattern_en low 1 cycle after gen_done; DONE with code 00, o_repair_valid=0, o_done=1.
- Single repair: first result 101 -> code 10, valid=1, second PATTERN; verify result 111 -> DONE, code 10 held, o_done=1.
- Double fault: first result 001 -> FAIL, o_fail=1, code 00, o_pattern_en=0.
- Verify fails: first result 011 -> code 01; verify result 011 -> FAIL, o_repair_valid=0.
- Timeout (macro on, TIMEOUT_CYCLES=20): no gen_done -> FAIL 20 cycles after entering PATTERN, o_timeout=1. Also: gen_done on the expiry cycle -> WAIT_RESULT, no fail.
- Abort and reset: i_abort during WAIT_RESULT -> IDLE next cycle, all outputs 0. Then restart and pulse i_rst_n low mid-PATTERN -> outputs 0 immediately. Also: i_start during busy is ignored.

Source files
------------

// File: rtl/mb_clk_repair_pkg.sv
// Shared encodings and defaults for the mainband clock-repair sequencer.
// Lane bit order everywhere is {ckp, ckn, trk}.
package mb_clk_repair_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_PATTERN     = 3'd1;
  localparam logic [2:0] ST_WAIT_RESULT = 3'd2;
  localparam logic [2:0] ST_DECIDE      = 3'd3;
  localparam logic [2:0] ST_DONE        = 3'd4;
  localparam logic [2:0] ST_FAIL        = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_PATTERN     = ST_PATTERN,
    S_WAIT_RESULT = ST_WAIT_RESULT,
    S_DECIDE      = ST_DECIDE,
    S_DONE        = ST_DONE,
    S_FAIL        = ST_FAIL
  } state_e;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_CKP  = 2'b01;
  localparam logic [1:0] REP_CKN  = 2'b10;
  localparam logic [1:0] REP_TRK  = 2'b11;

  localparam int DEF_TIMEOUT_CYCLES = 8000;
  localparam int DEF_TMR_W          = 13;

  function automatic logic [1:0] count_fails(input logic [2:0] ok);
    return 2'(!ok[2]) + 2'(!ok[1]) + 2'(!ok[0]);
  endfunction

  // Only meaningful when exactly one lane failed.
  function automatic logic [1:0] fail_lane(input logic [2:0] ok);
    if (!ok[2])      return REP_CKP;
    else if (!ok[1]) return REP_CKN;
    else             return REP_TRK;
  endfunction

endpackage

// File: rtl/mb_clk_repair_timer.sv
// Wait-state watchdog: expired is high once TIMEOUT_CYCLES-1 counted cycles have elapsed since clear.
// Clear has priority over enable; the count is held while enable is low.
module mb_clk_repair_timer
  import mb_clk_repair_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic i_sys_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (i_en) cnt_d = cnt_q + TMR_W'(1);
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mb_clk_repair_ctrl.sv
// MBINIT.REPAIRCLK sequencer: pattern, collect CKP/CKN/Track results, repair at most one lane, verify once.
// All outputs registered; the watchdog exists only when MB_CLKREPAIR_TIMEOUT_EN is defined.
module mb_clk_repair_ctrl
  import mb_clk_repair_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_gen_done,
  input  logic       i_result_valid,
  input  logic       i_ckp_ok,
  input  logic       i_ckn_ok,
  input  logic       i_trk_ok,
  output logic       o_pattern_en,
  output logic       o_busy,
  output logic [1:0] o_repair_code,
  output logic       o_repair_valid,
  output logic       o_done,
  output logic       o_fail,
  output logic       o_timeout
);

  state_e     state_q, state_d;
  logic       pass_q, pass_d;
  logic [2:0] ok_q, ok_d;
  logic       pe_q, pe_d;
  logic       busy_q, busy_d;
  logic [1:0] code_q, code_d;
  logic       rvld_q, rvld_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  logic       to_q, to_d;
  logic       tmr_expired;
  logic [1:0] nfail;

  assign nfail = count_fails(ok_q);

`ifdef MB_CLKREPAIR_TIMEOUT_EN
  logic tmr_clr, tmr_en;

  // Restart the count on every entry into a waiting state.
  assign tmr_clr = (state_d != state_q) &&
                   ((state_d == S_PATTERN) || (state_d == S_WAIT_RESULT));
  assign tmr_en  = (state_q == S_PATTERN) || (state_q == S_WAIT_RESULT);

  mb_clk_repair_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (tmr_clr),
    .i_en      (tmr_en),
    .o_expired (tmr_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = TIMEOUT_CYCLES[0] ^ TMR_W[0];
  assign tmr_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    ok_d    = ok_q;
    pe_d    = pe_q;
    busy_d  = busy_q;
    code_d  = code_q;
    rvld_d  = rvld_q;
    done_d  = done_q;
    fail_d  = fail_q;
    to_d    = to_q;
    if (i_abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      ok_d    = '0;
      pe_d    = 1'b0;
      busy_d  = 1'b0;
      code_d  = REP_NONE;
      rvld_d  = 1'b0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            state_d = S_PATTERN;
            pass_d  = 1'b0;
            ok_d    = '0;
            pe_d    = 1'b1;
            busy_d  = 1'b1;
            code_d  = REP_NONE;
            rvld_d  = 1'b0;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            to_d    = 1'b0;
          end
        end
        S_PATTERN: begin
          if (i_gen_done) begin
            state_d = S_WAIT_RESULT;
            pe_d    = 1'b0;
          end else if (tmr_expired) begin
            state_d = S_FAIL;
            pe_d    = 1'b0;
            busy_d  = 1'b0;
            rvld_d  = 1'b0;
            fail_d  = 1'b1;
            to_d    = 1'b1;
          end
        end
        S_WAIT_RESULT: begin
          if (i_result_valid) begin
            state_d = S_DECIDE;
            ok_d    = {i_ckp_ok, i_ckn_ok, i_trk_ok};
          end else if (tmr_expired) begin
            state_d = S_FAIL;
            pe_d    = 1'b0;
            busy_d  = 1'b0;
            rvld_d  = 1'b0;
            fail_d  = 1'b1;
            to_d    = 1'b1;
          end
        end
        S_DECIDE: begin
          if (nfail == 2'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (!pass_q && (nfail == 2'd1)) begin
            state_d = S_PATTERN;
            pe_d    = 1'b1;
            code_d  = fail_lane(ok_q);
            rvld_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            rvld_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
      ok_q    <= '0;
      pe_q    <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= REP_NONE;
      rvld_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      ok_q    <= ok_d;
      pe_q    <= pe_d;
      busy_q  <= busy_d;
      code_q  <= code_d;
      rvld_q  <= rvld_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  assign o_pattern_en   = pe_q;
  assign o_busy         = busy_q;
  assign o_repair_code  = code_q;
  assign o_repair_valid = rvld_q;
  assign o_done         = done_q;
  assign o_fail         = fail_q;
  assign o_timeout      = to_q;

endmodule

// File: tb/tb_mb_clk_repair_ctrl.sv
// Bench: scenarios are expanded into per-cycle input/expected-output timelines, then replayed
// while a negedge process compares every output against the timeline.
module tb_mb_clk_repair_ctrl;

`ifdef MB_CLKREPAIR_TIMEOUT_EN
  localparam int T     = 20;
  localparam bit TO_EN = 1'b1;
`else
  localparam int T     = 8000;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0, i_gen_done = 1'b0, i_result_valid = 1'b0;
  logic i_ckp_ok = 1'b0, i_ckn_ok = 1'b0, i_trk_ok = 1'b0;
  logic o_pattern_en, o_busy, o_repair_valid, o_done, o_fail, o_timeout;
  logic [1:0] o_repair_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mb_clk_repair_ctrl #(.TIMEOUT_CYCLES(T), .TMR_W(13)) dut (
    .i_sys_clk      (clk),
    .i_rst_n        (rst_n),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_gen_done     (i_gen_done),
    .i_result_valid (i_result_valid),
    .i_ckp_ok       (i_ckp_ok),
    .i_ckn_ok       (i_ckn_ok),
    .i_trk_ok       (i_trk_ok),
    .o_pattern_en   (o_pattern_en),
    .o_busy         (o_busy),
    .o_repair_code  (o_repair_code),
    .o_repair_valid (o_repair_valid),
    .o_done         (o_done),
    .o_fail         (o_fail),
    .o_timeout      (o_timeout)
  );

  typedef struct packed {
    logic start, abort, gd, rv;
    logic [2:0] ok;
  } in_t;

  typedef struct packed {
    logic pe, busy, rvld, done, fail, to;
    logic [1:0] code;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t out;
  } step_t;

  step_t steps[$];
  out_t  cur;
  out_t  exp_o;
  bit    pass_f, phase_ok, verify_f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pe"},   o_pattern_en,   0);
    chk({tag, "_busy"}, o_busy,         0);
    chk({tag, "_code"}, o_repair_code,  0);
    chk({tag, "_rvld"}, o_repair_valid, 0);
    chk({tag, "_done"}, o_done,         0);
    chk({tag, "_fail"}, o_fail,         0);
    chk({tag, "_to"},   o_timeout,      0);
  endtask

  always @(negedge clk) begin
    chk("pe",   o_pattern_en,   exp_o.pe);
    chk("busy", o_busy,         exp_o.busy);
    chk("code", o_repair_code,  exp_o.code);
    chk("rvld", o_repair_valid, exp_o.rvld);
    chk("done", o_done,         exp_o.done);
    chk("fail", o_fail,         exp_o.fail);
    chk("to",   o_timeout,      exp_o.to);
  end

  function automatic logic nz();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic push(input in_t i, input out_t o);
    step_t s;
    s.in  = i;
    s.out = o;
    steps.push_back(s);
  endtask

  task automatic to_fail();
    cur.pe   = 1'b0;
    cur.busy = 1'b0;
    cur.rvld = 1'b0;
    cur.fail = 1'b1;
    cur.to   = 1'b1;
  endtask

  task automatic s_start();
    in_t i;
    i = '0;
    i.start = 1'b1;
    i.gd    = nz();
    i.rv    = nz();
    cur = '0;
    cur.pe   = 1'b1;
    cur.busy = 1'b1;
    pass_f = 1'b0;
    push(i, cur);
  endtask

  // Busy cycles with no awaited event; start is asserted to show it is ignored.
  task automatic s_idle_busy(input int n);
    in_t i;
    for (int j = 0; j < n; j++) begin
      i = '0;
      i.start = 1'b1;
      i.ok = 3'($urandom_range(0, 7));
      push(i, cur);
    end
  endtask

  task automatic s_pattern(input int d);
    in_t i;
    phase_ok = 1'b0;
    for (int j = 0; j <= d; j++) begin
      i = '0;
      i.start = nz();
      i.rv    = nz();
      i.ok    = 3'($urandom_range(0, 7));
      if (j == d) begin
        i.gd = 1'b1;
        cur.pe = 1'b0;
        push(i, cur);
        phase_ok = 1'b1;
      end else if (TO_EN && j == T - 1) begin
        to_fail();
        push(i, cur);
        return;
      end else begin
        push(i, cur);
      end
    end
  endtask

  task automatic s_wait(input int r, input logic [2:0] bits);
    in_t i;
    phase_ok = 1'b0;
    for (int j = 0; j <= r; j++) begin
      i = '0;
      i.start = nz();
      i.gd    = nz();
      i.ok    = 3'($urandom_range(0, 7));
      if (j == r) begin
        i.rv = 1'b1;
        i.ok = bits;
        push(i, cur);
        phase_ok = 1'b1;
      end else if (TO_EN && j == T - 1) begin
        to_fail();
        push(i, cur);
        return;
      end else begin
        push(i, cur);
      end
    end
  endtask

  task automatic s_decide(input logic [2:0] bits);
    in_t i;
    int  nf;
    int  lane;
    i = '0;
    i.start = nz();
    i.gd    = nz();
    i.rv    = nz();
    i.ok    = 3'($urandom_range(0, 7));
    nf = 0;
    lane = 0;
    for (int k = 2; k >= 0; k--) begin
      if (!bits[k]) begin
        nf++;
        if (lane == 0) lane = 3 - k;
      end
    end
    verify_f = 1'b0;
    if (nf == 0) begin
      cur.done = 1'b1;
      cur.busy = 1'b0;
    end else if (!pass_f && nf == 1) begin
      cur.pe   = 1'b1;
      cur.code = 2'(lane);
      cur.rvld = 1'b1;
      pass_f   = 1'b1;
      verify_f = 1'b1;
    end else begin
      cur.fail = 1'b1;
      cur.busy = 1'b0;
      cur.rvld = 1'b0;
    end
    push(i, cur);
  endtask

  task automatic s_hold(input int n);
    in_t i;
    for (int j = 0; j < n; j++) begin
      i = '0;
      i.gd = nz();
      i.rv = nz();
      i.ok = 3'($urandom_range(0, 7));
      push(i, cur);
    end
  endtask

  task automatic s_abort();
    in_t i;
    i = '0;
    i.abort = 1'b1;
    i.start = nz();
    i.gd    = nz();
    i.rv    = nz();
    i.ok    = 3'($urandom_range(0, 7));
    cur = '0;
    push(i, cur);
  endtask

  task automatic run_seq(input int d1, input int r1, input logic [2:0] b1,
                         input int d2, input int r2, input logic [2:0] b2);
    s_start();
    s_pattern(d1);
    if (!phase_ok) return;
    s_wait(r1, b1);
    if (!phase_ok) return;
    s_decide(b1);
    if (!verify_f) return;
    s_pattern(d2);
    if (!phase_ok) return;
    s_wait(r2, b2);
    if (!phase_ok) return;
    s_decide(b2);
  endtask

  task automatic play();
    step_t s;
    while (steps.size() > 0) begin
      s = steps.pop_front();
      i_start        = s.in.start;
      i_abort        = s.in.abort;
      i_gen_done     = s.in.gd;
      i_result_valid = s.in.rv;
      i_ckp_ok       = s.in.ok[2];
      i_ckn_ok       = s.in.ok[1];
      i_trk_ok       = s.in.ok[0];
      @(posedge clk);
      #1;
      exp_o = s.out;
    end
    i_start = 1'b0; i_abort = 1'b0; i_gen_done = 1'b0; i_result_valid = 1'b0;
    i_ckp_ok = 1'b0; i_ckn_ok = 1'b0; i_trk_ok = 1'b0;
  endtask

  function automatic logic [2:0] rnd_bits();
    if ($urandom_range(0, 2) == 0) return 3'b111;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    int dc;
    exp_o = '0;
    cur   = '0;
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean pass
    dc = TO_EN ? 15 : 50;
    run_seq(dc, 5, 3'b111, 0, 0, 3'b111);
    chk("mdl_len_clean", steps.size(), dc + 9);
    chk("mdl_pe_drop", steps[dc + 1].out.pe, 0);
    s_hold(2);
    play();
    chk("clean_done", o_done, 1);
    chk("clean_code", o_repair_code, 0);
    chk("clean_rvld", o_repair_valid, 0);
    chk("clean_busy", o_busy, 0);

    // Single repair on CKN, verify passes
    run_seq(4, 3, 3'b101, 6, 2, 3'b111);
    s_hold(2);
    play();
    chk("rep_done", o_done, 1);
    chk("rep_code", o_repair_code, 2);
    chk("rep_rvld", o_repair_valid, 1);

    // Double fault
    run_seq(4, 3, 3'b001, 0, 0, 3'b111);
    s_hold(2);
    play();
    chk("dbl_fail", o_fail, 1);
    chk("dbl_code", o_repair_code, 0);
    chk("dbl_pe", o_pattern_en, 0);

    // Verify fails after CKP repair
    run_seq(4, 3, 3'b011, 5, 2, 3'b011);
    s_hold(2);
    play();
    chk("vfy_fail", o_fail, 1);
    chk("vfy_rvld", o_repair_valid, 0);
    chk("vfy_done", o_done, 0);

`ifdef MB_CLKREPAIR_TIMEOUT_EN
    run_seq(1000, 0, 3'b111, 0, 0, 3'b111);
    chk("mdl_len_to", steps.size(), 1 + T);
    play();
    chk("to_fail", o_fail, 1);
    chk("to_flag", o_timeout, 1);
    chk("to_pe", o_pattern_en, 0);
    run_seq(T - 1, 2, 3'b111, 0, 0, 3'b111);
    s_hold(2);
    play();
    chk("edge_done", o_done, 1);
    chk("edge_to", o_timeout, 0);
    run_seq(3, 1000, 3'b111, 0, 0, 3'b111);
    play();
    chk("wto_flag", o_timeout, 1);
`endif

    // Abort in WAIT_RESULT
    s_start();
    s_pattern(3);
    s_idle_busy(2);
    s_abort();
    play();
    chk_zero("abort");

    // Restart, then async reset mid-PATTERN
    s_start();
    s_idle_busy(5);
    play();
    chk("pre_rst_pe", o_pattern_en, 1);
    #1;
    rst_n = 1'b0;
    exp_o = '0;
    cur   = '0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        s_start();
        s_idle_busy($urandom_range(0, 12));
        s_abort();
      end else begin
        run_seq($urandom_range(0, 24), $urandom_range(0, 24), rnd_bits(),
                $urandom_range(0, 24), $urandom_range(0, 24), rnd_bits());
        s_hold($urandom_range(1, 4));
        if ($urandom_range(0, 3) == 0) s_abort();
      end
      play();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
